// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - arbitrates video, CPU and DMA byte requests onto two 256Kx16 async SRAM banks
module sram_arbiter #(
    parameter int ACCESS_CYCLES = 2,
    parameter int ADDR_W        = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic [7:0]        vid_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_ack,
    output logic [7:0]        cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [7:0]        dma_wdata,
    output logic              dma_ack,
    output logic [7:0]        dma_rdata,
    output logic [ADDR_W-3:0] ram_addr,
    output logic              ram_rw_n,
    output logic              ram_oe_n,
    output logic              ram0_cs_n,
    output logic              ram1_cs_n,
    output logic              ram0_be0_n,
    output logic              ram0_be1_n,
    output logic              ram1_be0_n,
    output logic              ram1_be1_n,
    output logic [15:0]       ram_dout,
    output logic              ram_dout_oe,
    input  logic [15:0]       ram_din0,
    input  logic [15:0]       ram_din1,
    output logic              busy
);

    localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RECOVER} state_t;
    typedef enum logic [1:0] {ID_NONE, ID_VID, ID_CPU, ID_DMA} id_t;

    state_t            r_state, w_next_state;
    logic [CW-1:0]     r_cnt, w_next_cnt;
    id_t               r_id, w_gnt;
    logic              r_we, r_bank, r_lane, r_rr_cpu;
    logic              w_g_we, w_start, w_last, w_drive, w_we, w_bank, w_lane;
    logic [ADDR_W-1:0] w_g_addr;
    logic [7:0]        w_g_wdata, w_rbyte;
    logic [15:0]       w_din;

    // Video always wins; CPU/DMA ties go to whichever was not served last.
    always_comb begin
        w_gnt = ID_NONE;
        if (vid_req)                 w_gnt = ID_VID;
        else if (cpu_req && dma_req) w_gnt = r_rr_cpu ? ID_CPU : ID_DMA;
        else if (cpu_req)            w_gnt = ID_CPU;
        else if (dma_req)            w_gnt = ID_DMA;
    end

    always_comb begin
        w_g_we    = 1'b0;
        w_g_addr  = '0;
        w_g_wdata = '0;
        case (w_gnt)
            ID_VID: w_g_addr = vid_addr;
            ID_CPU: begin w_g_we = cpu_we; w_g_addr = cpu_addr; w_g_wdata = cpu_wdata; end
            ID_DMA: begin w_g_we = dma_we; w_g_addr = dma_addr; w_g_wdata = dma_wdata; end
            default: ;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_gnt != ID_NONE) begin
                    w_next_state = S_ACCESS;
                    w_next_cnt   = '0;
                end
            end
            S_ACCESS: begin
                if (r_cnt == CW'(ACCESS_CYCLES - 1)) begin
                    w_next_state = S_RECOVER;
                    w_next_cnt   = '0;
                    w_last       = 1'b1;
                end else begin
                    w_next_cnt = r_cnt + CW'(1);
                end
            end
            S_RECOVER: w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // Strobes are registered from the next state, so the grant cycle uses the live request fields.
    assign w_start = (r_state == S_IDLE) && (w_gnt != ID_NONE);
    assign w_drive = (w_next_state == S_ACCESS);
    assign w_we    = w_start ? w_g_we : r_we;
    assign w_bank  = w_start ? w_g_addr[ADDR_W-1] : r_bank;
    assign w_lane  = w_start ? w_g_addr[0] : r_lane;
    assign w_din   = r_bank ? ram_din1 : ram_din0;
    assign w_rbyte = r_lane ? w_din[15:8] : w_din[7:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_id        <= ID_NONE;
            r_we        <= 1'b0;
            r_bank      <= 1'b0;
            r_lane      <= 1'b0;
            r_rr_cpu    <= 1'b1;
            ram_addr    <= '0;
            ram_dout    <= '0;
            ram_dout_oe <= 1'b0;
            ram_rw_n    <= 1'b1;
            ram_oe_n    <= 1'b1;
            ram0_cs_n   <= 1'b1;
            ram1_cs_n   <= 1'b1;
            ram0_be0_n  <= 1'b1;
            ram0_be1_n  <= 1'b1;
            ram1_be0_n  <= 1'b1;
            ram1_be1_n  <= 1'b1;
            vid_ack     <= 1'b0;
            cpu_ack     <= 1'b0;
            dma_ack     <= 1'b0;
            vid_rdata   <= '0;
            cpu_rdata   <= '0;
            dma_rdata   <= '0;
            busy        <= 1'b0;
        end else begin
            if (w_start) begin
                r_id     <= w_gnt;
                r_we     <= w_g_we;
                r_bank   <= w_g_addr[ADDR_W-1];
                r_lane   <= w_g_addr[0];
                ram_addr <= w_g_addr[ADDR_W-2:1];
                if (w_g_we)
                    ram_dout <= {w_g_wdata, w_g_wdata};
                if (w_gnt == ID_CPU)      r_rr_cpu <= 1'b0;
                else if (w_gnt == ID_DMA) r_rr_cpu <= 1'b1;
            end
            ram0_cs_n   <= !(w_drive && !w_bank);
            ram1_cs_n   <= !(w_drive && w_bank);
            ram0_be0_n  <= !(w_drive && !w_bank && !w_lane);
            ram0_be1_n  <= !(w_drive && !w_bank && w_lane);
            ram1_be0_n  <= !(w_drive && w_bank && !w_lane);
            ram1_be1_n  <= !(w_drive && w_bank && w_lane);
            ram_oe_n    <= !(w_drive && !w_we);
            ram_rw_n    <= !(w_drive && w_we);
            ram_dout_oe <= (w_next_state != S_IDLE) && w_we;
            busy        <= (w_next_state != S_IDLE);
            vid_ack     <= w_last && (r_id == ID_VID);
            cpu_ack     <= w_last && (r_id == ID_CPU);
            dma_ack     <= w_last && (r_id == ID_DMA);
            if (w_last && !r_we) begin
                case (r_id)
                    ID_VID:  vid_rdata <= w_rbyte;
                    ID_CPU:  cpu_rdata <= w_rbyte;
                    ID_DMA:  dma_rdata <= w_rbyte;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the two external 256Kx16 asynchronous SRAM banks (common address/RW/OE, per-bank CS and byte enables) between three byte-wide requesters: video fetch, CPU and DMA (disk/peripheral).
- Sits between the Apple core and the board RAM pins.
- Sequences each access as a fixed-length strobe cycle and returns read data with a one-cycle ack.
- Tristate buffering of the RAM data pins is done at the top level from ram_dout/ram_dout_oe.

Parameters:
ACCESS_CYCLES, 2, cycles CS plus OE/WE are held active per access (min 1)
ADDR_W, 20, requester byte-address width; bit 0 selects byte lane, bit ADDR_W-1 selects bank, bits ADDR_W-2:1 form the word address

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
vid_req  in  1  video read request, level, held until ack
vid_addr  in  20  video byte address
vid_ack  out  1  one-cycle pulse, vid_rdata valid
vid_rdata  out  8  video read data
cpu_req  in  1  CPU request
cpu_we  in  1  1=write, 0=read
cpu_addr  in  20  CPU byte address
cpu_wdata  in  8  CPU write data
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  8  CPU read data
dma_req, dma_we, dma_addr[20], dma_wdata[8], dma_ack, dma_rdata[8]  same as CPU
ram_addr  out  18  common SRAM word address
ram_rw_n  out  1  common write strobe, active low
ram_oe_n  out  1  common output enable, active low
ram0_cs_n, ram1_cs_n  out  1 each  bank chip selects
ram0_be0_n, ram0_be1_n, ram1_be0_n, ram1_be1_n  out  1 each  byte enables, active low
ram_dout  out  16  write data, {wdata,wdata}
ram_dout_oe  out  1  1 = top drives RAM data pins
ram_din0, ram_din1  in  16 each  RAM bank read data
busy  out  1  state != IDLE

Behaviour:
- All outputs registered. Reset (async, immediate): state=IDLE; all *_n outputs=1; acks=0; rdata=0; ram_addr=0; ram_dout=0; ram_dout_oe=0; rr pointer=CPU-preferred.
- States: IDLE, ACCESS, RECOVER.
- IDLE: arbitrate among asserted reqs.
  - Priority: vid first; otherwise CPU vs DMA round-robin. The pointer prefers the one not granted last and toggles only on a CPU/DMA grant.
  - On grant: latch requester id, we, addr, wdata; drive ram_addr=addr[18:1]; go to ACCESS.
  - No req: stay IDLE, strobes inactive.
- ACCESS, ACCESS_CYCLES cycles, counter from 0:
  - Selected bank cs_n=0; other bank cs_n=1.
  - Lane be_n=0 (addr[0]=0: be0, 1: be1); other lane be_n=1.
  - Read: oe_n=0, rw_n=1, dout_oe=0.
  - Write: oe_n=1, rw_n=0, dout_oe=1, ram_dout={wdata,wdata}.
  - Read data captured from the selected bank/lane on the last ACCESS cycle edge.
- RECOVER (1 cycle):
  - cs_n, oe_n, rw_n, be_n all 1.
  - Write data and dout_oe stay asserted (hold time).
  - Granted ack=1; its rdata updated (reads only; writes leave rdata unchanged).
  - Then IDLE.
- Latency: req sampled in IDLE at cycle 0 -> ack in cycle ACCESS_CYCLES+1 (3 by default).
  - Back-to-back throughput: one access per ACCESS_CYCLES+2 cycles.
- Requester handshake:
  - Keeps req/addr/we/wdata stable until it samples ack, then drops req or presents a new request on the following cycle.
  - Changing inputs mid-access is ignored, since they are latched at grant.
- Ack of one requester never coincides with another's; at most one ack high per cycle.
- vid_req with no other traffic is granted every access slot; CPU/DMA wait (no starvation guard).
- Reset mid-ACCESS or RECOVER: strobes deassert asynchronously; the access is dropped with no ack. Requests still high after reset are re-arbitrated from IDLE.
- ram_addr holds its last value in IDLE.

Test Plan:
- Reset: assert rst during CPU ACCESS -> next sample all cs_n/oe_n/rw_n/be_n=1, ram_dout_oe=0, cpu_ack never pulses.
- CPU write 0x5A to 0x00003 -> ram_addr=0x00001, ram0_cs_n=0, ram0_be1_n=0, ram0_be0_n=1, ram1_cs_n=1, rw_n low 2 cycles, ram_dout=0x5A5A, cpu_ack at cycle 3. Then read 0x00003 -> cpu_rdata=0x5A at ack.
- Bank 1: DMA read 0x80000 with ram_din1=0x12AB -> ram1_cs_n=0, ram_addr=0, ram0_cs_n=1, dma_rdata=0xAB.
- All three req together from reset, held and re-asserted after ack -> grant order vid, vid... (vid always wins); vid dropped -> cpu, dma, cpu, dma alternate.
- vid+cpu+dma asserted once each after reset, each dropped after its ack -> acks at cycles 3, 7, 11 in order vid, cpu, dma.
- ACCESS_CYCLES=1 build: CPU read -> ack at cycle 2, oe_n low exactly 1 cycle.
